// File: rtl/knap_pkg.sv
// knap_pkg: shared constants and enums for the knapsack subset search.
// Holds default sizes, the sum-width rule, FSM states and cfg_field codes.
package knap_pkg;

    localparam int N_ITEMS_DEF = 6;
    localparam int W_DEF       = 8;

    // Sums of up to N items never overflow this width.
    function automatic int sum_w(input int n, input int w);
        return w + $clog2(n) + 1;
    endfunction

    localparam int SUM_W_DEF = sum_w(N_ITEMS_DEF, W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLD_VALUE  = 2'd0,
        FLD_WEIGHT = 2'd1,
        FLD_VOLUME = 2'd2,
        FLD_NONE   = 2'd3
    } field_t;

endpackage

// File: rtl/knap_search_ctrl_eval.sv
// knap_eval: combinational constraint check for one subset mask.
// In: mask, flat item tables, thresholds. Out: is_valid, total_value.
module knap_eval
    import knap_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF,
    parameter int W       = W_DEF
) (
    input  logic [N_ITEMS-1:0]            mask,
    input  logic [N_ITEMS*W-1:0]          val_tbl,
    input  logic [N_ITEMS*W-1:0]          wgt_tbl,
    input  logic [N_ITEMS*W-1:0]          vol_tbl,
    input  logic [W-1:0]                  min_value,
    input  logic [W-1:0]                  max_weight,
    input  logic [W-1:0]                  max_volume,
    output logic                          is_valid,
    output logic [W+$clog2(N_ITEMS):0]    total_value
);

    localparam int SW = sum_w(N_ITEMS, W);

    logic [SW-1:0] sum_v;
    logic [SW-1:0] sum_w_q;
    logic [SW-1:0] sum_l;

    always_comb begin
        sum_v   = '0;
        sum_w_q = '0;
        sum_l   = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (mask[i]) begin
                sum_v   = sum_v   + SW'(val_tbl[i*W +: W]);
                sum_w_q = sum_w_q + SW'(wgt_tbl[i*W +: W]);
                sum_l   = sum_l   + SW'(vol_tbl[i*W +: W]);
            end
        end
    end

    assign is_valid = (sum_v >= SW'(min_value))
                   && (sum_w_q <= SW'(max_weight))
                   && (sum_l <= SW'(max_volume));

    assign total_value = sum_v;

endmodule

// File: rtl/knap_search_ctrl.sv
// knap_search_ctrl: exhaustive subset search, one mask per clock.
// Ports: clk, rst_n, cfg_* table write, thresholds, start/abort in;
//        busy, done, found, best_mask, best_value, valid_count out.
// Build option: define KNAP_COUNT_EN to get the valid_count counter.
module knap_search_ctrl
    import knap_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF,
    parameter int W       = W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(N_ITEMS)-1:0]   cfg_item,
    input  logic [1:0]                   cfg_field,
    input  logic [W-1:0]                 cfg_data,
    input  logic [W-1:0]                 min_value,
    input  logic [W-1:0]                 max_weight,
    input  logic [W-1:0]                 max_volume,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [N_ITEMS-1:0]           best_mask,
    output logic [W+$clog2(N_ITEMS):0]   best_value,
    output logic [N_ITEMS:0]             valid_count
);

    localparam int IW = $clog2(N_ITEMS);
    localparam int SW = sum_w(N_ITEMS, W);
    localparam logic [N_ITEMS-1:0] MASK_ONE = 1;

    state_t state_q, state_d;

    logic [N_ITEMS-1:0]   mask_q;
    logic [N_ITEMS*W-1:0] val_q, wgt_q, vol_q;
    logic [W-1:0]         min_q, wmax_q, vmax_q;
    logic                 found_q;
    logic [N_ITEMS-1:0]   best_mask_q;
    logic [SW-1:0]        best_val_q;

    logic          is_valid;
    logic [SW-1:0] total;
    logic          accept, scanning, last;

    assign scanning = (state_q == ST_SCAN);
    assign accept   = (state_q == ST_IDLE) && start && !abort;
    assign last     = &mask_q;

    knap_eval #(.N_ITEMS(N_ITEMS), .W(W)) u_eval (
        .mask        (mask_q),
        .val_tbl     (val_q),
        .wgt_tbl     (wgt_q),
        .vol_tbl     (vol_q),
        .min_value   (min_q),
        .max_weight  (wmax_q),
        .max_volume  (vmax_q),
        .is_valid    (is_valid),
        .total_value (total)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start && !abort) state_d = ST_SCAN;
            ST_SCAN: begin
                if (abort)     state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (1'b1)
            (state_q == ST_SCAN): busy = 1'b1;
            (state_q == ST_DONE): done = 1'b1;
            default: ;
        endcase
    end

    // Table is frozen while scanning so a search sees one consistent set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            wgt_q <= '0;
            vol_q <= '0;
        end else if (cfg_we && !scanning) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (cfg_item == IW'(i)) begin
                    case (cfg_field)
                        FLD_VALUE:  val_q[i*W +: W] <= cfg_data;
                        FLD_WEIGHT: wgt_q[i*W +: W] <= cfg_data;
                        FLD_VOLUME: vol_q[i*W +: W] <= cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            min_q       <= '0;
            wmax_q      <= '0;
            vmax_q      <= '0;
            found_q     <= 1'b0;
            best_mask_q <= '0;
            best_val_q  <= '0;
        end else if (accept) begin
            mask_q      <= '0;
            min_q       <= min_value;
            wmax_q      <= max_weight;
            vmax_q      <= max_volume;
            found_q     <= 1'b0;
            best_mask_q <= '0;
            best_val_q  <= '0;
        end else if (scanning) begin
            if (abort) begin
                found_q <= 1'b0;
            end else begin
                mask_q <= mask_q + MASK_ONE;
                // Strict compare keeps the lowest mask on value ties.
                if (is_valid && (!found_q || total > best_val_q)) begin
                    found_q     <= 1'b1;
                    best_mask_q <= mask_q;
                    best_val_q  <= total;
                end
            end
        end
    end

`ifdef KNAP_COUNT_EN
    localparam logic [N_ITEMS:0] CNT_ONE = 1;

    logic [N_ITEMS:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= '0;
        else if (scanning && !abort && is_valid)
            cnt_q <= cnt_q + CNT_ONE;
    end

    assign valid_count = cnt_q;
`else
    assign valid_count = '0;
`endif

    assign found      = found_q;
    assign best_mask  = best_mask_q;
    assign best_value = best_val_q;

endmodule
